keccak_state_mem: RTL and testbench
===================================

# keccak_state_mem

- Holds the 64-line × 25-bit hashing state: one register per lane bit-slice, indexed by the 6-bit slice counter.
- Acts as the responder on the step-module memory port: serves `line_in` to step modules such as AddRoundConstant and accepts their `write_enable`/`write_value` write-backs.
- Also provides the other end of the state path: loads an initial state from a streaming source and dumps the final state to a streaming sink, both with valid/ready handshakes.
- Sits between the top-level controller and all round-step datapaths.

## Interface

Parameters:
- `WIDTH`, 25, line width (5×5 lane bits per slice)
- `DEPTH`, 64, number of lines (slices)
- `AW`, 6, line address width

Ports:
- `clk`  in  1  clock. The block uses one clock.
- `rst`  in  1  synchronous, active-low reset.
- `load_start`  in  1  request to start a 64-line load; sampled in IDLE only.
- `in_valid`  in  1  `in_line` holds a valid line.
- `in_line`  in  WIDTH  incoming state line.
- `in_ready`  out  1  block accepts a line this cycle.
- `load_done`  out  1  one-cycle pulse after the final line is accepted.
- `dump_start`  in  1  request to start a 64-line dump; sampled in IDLE only.
- `out_valid`  out  1  `out_line` is valid.
- `out_ready`  in  1  sink accepts `out_line`.
- `out_line`  out  WIDTH  line `mem[cnt]`.
- `out_addr`  out  AW  index of `out_line`.
- `dump_done`  out  1  one-cycle pulse after the final line is transferred.
- `step_addr`  in  AW  step-module read/write address (the step's `cnt_value`).
- `step_line`  out  WIDTH  combinational `mem[step_addr]` (the step's `line_in`).
- `step_we`  in  1  step write enable.
- `step_wdata`  in  WIDTH  step write data.
- `busy`  out  1  high whenever the state is not IDLE.
- `data_out`  out  WIDTH×DEPTH  full-state view, `data_out[i] = mem[i]`.

## Operation

- FSM has three states: IDLE, LOAD, DUMP. It also keeps a 6-bit counter `cnt`.
- IDLE:
  - If `step_we` is high, `mem[step_addr] <= step_wdata` at the clock edge.
  - `load_start` moves to LOAD with `cnt <= 0`.
  - Otherwise, `dump_start` moves to DUMP with `cnt <= 0`.
  - If both are high, load wins and `dump_start` is dropped.
- LOAD:
  - `in_ready = 1`.
  - On `in_valid & in_ready`: `mem[cnt] <= in_line`, `cnt <= cnt + 1`.
  - No accept leaves `mem` and `cnt` unchanged (stall).
  - Accept at `cnt == 63` wraps `cnt` to 0, moves to IDLE, and registers `load_done = 1` for the next cycle.
- DUMP:
  - `out_valid = 1`, `out_line = mem[cnt]`, `out_addr = cnt`.
  - On `out_ready`: `cnt <= cnt + 1`.
  - Transfer at `cnt == 63` moves to IDLE and registers `dump_done = 1`.
- Outside IDLE:
  - `step_we` is ignored.
  - `load_start`/`dump_start` are ignored.
  - `step_line` and `data_out` keep reflecting `mem`.
- `in_ready` and `out_valid` are 0 outside their own states.
- Reset (`rst == 0` at an edge), including mid-LOAD or mid-DUMP:
  - State goes to IDLE and `cnt` to 0.
  - All 64 lines are cleared to 0.
  - `load_done` and `dump_done` go to 0.
  - A partial transfer is abandoned and not resumed.

## Timing

- Reset values:
  - `in_ready`, `out_valid`, `load_done`, `dump_done`, `busy` = 0.
  - `out_addr` = 0, `out_line` = 0.
  - `step_line` = 0 and all `data_out` = 0.
- Start latency: `load_start` high at edge N means LOAD from cycle N+1, with `in_ready` high in that cycle. DUMP behaves the same way with `out_valid`.
- Full-rate load takes 64 cycles in LOAD. `load_done` is high in cycle N+65, when the FSM is already IDLE and `busy` is 0.
- A new `load_start` or `dump_start` is honoured in the same cycle as `load_done` or `dump_done`.
- `step_line` is purely combinational from `step_addr` (zero-cycle read). A step write is visible on `step_line` and `data_out` from the cycle after the edge.
- Read-before-write within a cycle: `step_line` shows the old value during the write cycle.
- `out_line` holds stable while `out_valid & !out_ready`.
- `cnt` is 6 bits and wraps modulo 64; no other widths are truncated.

## Test plan

- Reset then load: apply reset, then stream lines `i*3+1` for i = 0..63 with `in_valid` held high. Expect `data_out[i] == i*3+1`, `load_done` exactly once at cycle 65 after `load_start`, and `busy` low afterwards.
- Backpressured dump: after the load above, toggle `out_ready` every other cycle. Expect 64 transfers with `out_addr` 0..63 in order, `out_line` stable while stalled, and one `dump_done`.
- Step write-back: in IDLE, drive `step_addr` = 5, `step_wdata` = 25'h1ABCDEF, `step_we` = 1 for one cycle. Expect `step_line` to show the old value that cycle and 25'h1ABCDEF the next.
- Ignored writes and starts: during LOAD, pulse `step_we` at address 10 and assert `dump_start`. Expect `mem[10]` to equal only the loaded value and no DUMP entry; `load_start`+`dump_start` together in IDLE enter LOAD.
- Reset mid-load: assert reset after 20 accepts. Expect the next cycle to be IDLE, all lines 0, `in_ready` 0, and no `load_done`.
- Input stall: insert 3-cycle `in_valid` gaps at lines 0, 31 and 63. Expect correct contents, `cnt` held during gaps, and `load_done` delayed by 9 cycles.

Source files
------------

// File: rtl/keccak_state_mem.sv
// Keccak 64x25 state store: step-module read/write port plus streaming load and dump.
// One register line per slice; the FSM sequences whole-state transfers over cnt.

module keccak_state_line #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst)    q <= '0;
    else if (we) q <= wdata;
  end
endmodule

module keccak_state_mem #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_line,
  output logic                        in_ready,
  output logic                        load_done,
  input  logic                        dump_start,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_line,
  output logic [AW-1:0]               out_addr,
  output logic                        dump_done,
  input  logic [AW-1:0]               step_addr,
  output logic [WIDTH-1:0]            step_line,
  input  logic                        step_we,
  input  logic [WIDTH-1:0]            step_wdata,
  output logic                        busy,
  output logic [DEPTH-1:0][WIDTH-1:0] data_out
);
  typedef enum logic [1:0] {IDLE, LOAD, DUMP} state_t;

  state_t                      state, state_nxt;
  logic [AW-1:0]               cnt, cnt_nxt;
  logic                        load_done_nxt, dump_done_nxt;
  logic                        wr_en;
  logic [AW-1:0]               wr_addr;
  logic [WIDTH-1:0]            wr_data;
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      load_done <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      load_done <= load_done_nxt;
      dump_done <= dump_done_nxt;
    end
  end

  // Single write port shared by step write-back (IDLE) and streaming load (LOAD).
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    load_done_nxt = 1'b0;
    dump_done_nxt = 1'b0;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = step_addr;
    wr_data       = step_wdata;
    case (state)
      IDLE: begin
        wr_en = step_we;
        if (load_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end else if (dump_start) begin
          state_nxt = DUMP;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        wr_addr  = cnt;
        wr_data  = in_line;
        if (in_valid) begin
          wr_en   = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) begin
            cnt_nxt       = '0;
            state_nxt     = IDLE;
            load_done_nxt = 1'b1;
          end
        end
      end
      DUMP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) begin
            cnt_nxt       = '0;
            state_nxt     = IDLE;
            dump_done_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_line
    keccak_state_line #(.WIDTH(WIDTH)) u_line (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en && (wr_addr == AW'(g))),
      .wdata (wr_data),
      .q     (mem[g])
    );
  end

  assign step_line = mem[step_addr];
  assign out_line  = mem[cnt];
  assign out_addr  = cnt;
  assign busy      = (state != IDLE);
  assign data_out  = mem;
endmodule

// File: tb/tb_keccak_state_mem.sv
// Directed bench for keccak_state_mem: loads, backpressured dump, step port table, resets.
// A local exp_mem array tracks what every line should hold.

module tb_keccak_state_mem;
  localparam int WIDTH = 25;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        load_start, in_valid, dump_start, out_ready, step_we;
  logic [WIDTH-1:0]            in_line, step_wdata;
  logic [AW-1:0]               step_addr;
  logic                        in_ready, load_done, out_valid, dump_done, busy;
  logic [WIDTH-1:0]            out_line, step_line;
  logic [AW-1:0]               out_addr;
  logic [DEPTH-1:0][WIDTH-1:0] data_out;

  keccak_state_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_line(in_line), .in_ready(in_ready), .load_done(load_done),
    .dump_start(dump_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_line(out_line), .out_addr(out_addr), .dump_done(dump_done),
    .step_addr(step_addr), .step_line(step_line), .step_we(step_we),
    .step_wdata(step_wdata), .busy(busy), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]    addr;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] exp_line;
  } step_vec_t;

  int               checks = 0;
  int               errors = 0;
  int               n_ld = 0;
  int               n_dd = 0;
  logic [WIDTH-1:0] exp_mem [DEPTH];
  step_vec_t        vec [8];

  always @(negedge clk) begin
    if (load_done) n_ld++;
    if (dump_done) n_dd++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_mem(input string nm);
    int nbad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (data_out[i] !== exp_mem[i]) nbad++;
    chk(nm, nbad, 0);
  endtask

  // Streams 64 lines (i*mul+add) assuming LOAD was entered on the previous edge.
  task automatic load_lines(input int mul, input int add, input bit gaps, input bit poke,
                            input int exp_ticks);
    int ticks = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gaps && (i == 0 || i == 31 || i == 63)) begin
        in_valid = 1'b0;
        repeat (3) begin tick(); ticks++; end
        chk("gap_in_ready", in_ready, 1);
        chk("gap_line_held", data_out[i], exp_mem[i]);
      end
      in_valid = 1'b1;
      in_line  = WIDTH'(i * mul + add);
      if (poke && i == 12) begin
        step_we    = 1'b1;
        step_addr  = 6'd10;
        step_wdata = 25'h0000155;
        dump_start = 1'b1;
      end
      tick(); ticks++;
      step_we    = 1'b0;
      dump_start = 1'b0;
      exp_mem[i] = WIDTH'(i * mul + add);
      if (i < DEPTH - 1) chk("load_done_early", load_done, 0);
    end
    in_valid = 1'b0;
    chk("load_ticks", ticks, exp_ticks);
    chk("load_done_pulse", load_done, 1);
    chk("load_busy_after", busy, 0);
    chk("load_no_dump", out_valid, 0);
  endtask

  initial begin
    int k, c;
    logic rdy;
    rst = 1'b0; load_start = 1'b0; in_valid = 1'b0; dump_start = 1'b0;
    out_ready = 1'b0; step_we = 1'b0; in_line = '0; step_wdata = '0; step_addr = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;

    vec[0] = '{6'd5,  1'b1, 25'h1ABCDEF, 25'd16};
    vec[1] = '{6'd5,  1'b0, 25'h0000000, 25'h1ABCDEF};
    vec[2] = '{6'd63, 1'b0, 25'h0000000, 25'd190};
    vec[3] = '{6'd0,  1'b1, 25'h1FFFFFF, 25'd1};
    vec[4] = '{6'd0,  1'b0, 25'h0000000, 25'h1FFFFFF};
    vec[5] = '{6'd10, 1'b0, 25'h0000000, 25'd31};
    vec[6] = '{6'd10, 1'b1, 25'h0000AAA, 25'd31};
    vec[7] = '{6'd10, 1'b0, 25'h0000000, 25'h0000AAA};

    @(negedge clk); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_dump_done", dump_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_line", out_line, 0);
    chk("rst_step_line", step_line, 0);
    chk_mem("rst_data_out");
    rst = 1'b1;
    tick();

    // load_start and dump_start together: load must win
    load_start = 1'b1; dump_start = 1'b1;
    tick();
    load_start = 1'b0; dump_start = 1'b0;
    chk("start_in_ready", in_ready, 1);
    chk("start_no_dump", out_valid, 0);
    chk("start_busy", busy, 1);
    load_lines(3, 1, 1'b0, 1'b1, 64);
    chk_mem("load1_contents");
    chk("load1_line10", data_out[10], 25'd31);
    tick();
    chk("load_done_one_cycle", load_done, 0);
    chk("load1_pulses", n_ld, 1);

    for (int v = 0; v < 8; v++) begin
      step_addr  = vec[v].addr;
      step_we    = vec[v].we;
      step_wdata = vec[v].wdata;
      #1;
      chk($sformatf("step_vec%0d", v), step_line, vec[v].exp_line);
      tick();
      if (vec[v].we) exp_mem[vec[v].addr] = vec[v].wdata;
    end
    step_we = 1'b0;
    chk_mem("step_contents");

    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    chk("dump_busy", busy, 1);
    k = 0; c = 0;
    while (k < DEPTH && c < 300) begin
      chk("dump_valid", out_valid, 1);
      chk("dump_addr", out_addr, k);
      chk("dump_line", out_line, exp_mem[k]);
      rdy = c[0];
      out_ready = rdy;
      tick(); c++;
      if (rdy) k++;
    end
    out_ready = 1'b0;
    chk("dump_xfers", k, DEPTH);
    chk("dump_done_pulse", dump_done, 1);
    chk("dump_busy_after", busy, 0);

    // new load honoured in the dump_done cycle, then stalls at lines 0, 31, 63
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("dump_done_one_cycle", dump_done, 0);
    chk("restart_in_ready", in_ready, 1);
    chk("dump_pulses", n_dd, 1);
    load_lines(5, 7, 1'b1, 1'b0, 73);
    chk_mem("load2_contents");
    tick();
    chk("load2_pulses", n_ld, 2);

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_line  = WIDTH'(i + 100);
      tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_load_done", load_done, 0);
    chk("midrst_out_addr", out_addr, 0);
    chk_mem("midrst_cleared");
    repeat (70) tick();
    chk("midrst_no_resume", busy, 0);
    chk("midrst_pulses", n_ld, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
